// File: rtl/controle_escrita_registrador_if.sv
// Write-back request/handshake bundle between the control unit, the input device
// and the write-back sequencer.
interface controle_escrita_registrador_if;
    logic       Inicio;
    logic [1:0] Tipo;
    logic [4:0] Reg_Destino;
    logic       ES_Valido;
    logic       ES_Aceito;
    logic [1:0] Seletor_W_Data;
    logic       Escreve_Reg;
    logic [4:0] Reg_Endereco_W;
    logic       Parada;
    logic       Pronto;
    logic       Erro_Protocolo;

    modport master (
        output Inicio, Tipo, Reg_Destino, ES_Valido,
        input  ES_Aceito, Seletor_W_Data, Escreve_Reg, Reg_Endereco_W, Parada, Pronto,
               Erro_Protocolo
    );

    modport slave (
        input  Inicio, Tipo, Reg_Destino, ES_Valido,
        output ES_Aceito, Seletor_W_Data, Escreve_Reg, Reg_Endereco_W, Parada, Pronto,
               Erro_Protocolo
    );
endinterface

// File: rtl/controle_escrita_registrador.sv
// Write-back sequencer: selects the register-file write source, waits out memory
// latency or the input-device handshake, then issues a single write pulse.
module controle_escrita_registrador #(
    parameter int unsigned MEM_LATENCIA = 1
) (
    input logic                            clock,
    input logic                            reset,
    controle_escrita_registrador_if.slave  bus
);

    typedef enum logic [2:0] {
        StOcioso,
        StEsperaMem,
        StEsperaEs,
        StEscreve,
        StFimSemEscrita
    } estado_e;

    localparam logic [3:0] LatCnt = 4'(MEM_LATENCIA);

    estado_e    state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [4:0] addr_q, addr_d;
    logic       escreve_q, escreve_d;
    logic       pronto_q, pronto_d;
    logic       aceito_q, aceito_d;
    logic       parada_q, parada_d;
    logic       erro_q, erro_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        addr_d  = addr_q;

        unique case (state_q)
            StOcioso: begin
                if (bus.Inicio) begin
                    sel_d  = (bus.Tipo == 2'b10) ? 2'b00 : bus.Tipo;
                    addr_d = bus.Reg_Destino;
                    case (bus.Tipo)
                        2'b00: state_d = StEscreve;
                        2'b01: begin
                            if (LatCnt == 4'd0) begin
                                state_d = StEscreve;
                            end else begin
                                state_d = StEsperaMem;
                                cnt_d   = LatCnt;
                            end
                        end
                        2'b11:   state_d = StEsperaEs;
                        default: state_d = StFimSemEscrita;
                    endcase
                end
            end
            StEsperaMem: begin
                // Counter at 1 marks the last wait cycle.
                if (cnt_q <= 4'd1) begin
                    state_d = StEscreve;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StEsperaEs: begin
                if (bus.ES_Valido) begin
                    state_d = StEscreve;
                end
            end
            StEscreve, StFimSemEscrita: state_d = StOcioso;
            default:                    state_d = StOcioso;
        endcase

        // Outputs are registered from the next state so they are glitch-free Moore flops.
        escreve_d = (state_d == StEscreve) && (addr_d != 5'd0);
        pronto_d  = (state_d == StEscreve) || (state_d == StFimSemEscrita);
        aceito_d  = (state_d == StEscreve) && (sel_d == 2'b11);
        parada_d  = (state_d == StEsperaMem) || (state_d == StEsperaEs);
        erro_d    = erro_q || (bus.Inicio && (state_q != StOcioso));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StOcioso;
            cnt_q     <= 4'd0;
            sel_q     <= 2'b00;
            addr_q    <= 5'd0;
            escreve_q <= 1'b0;
            pronto_q  <= 1'b0;
            aceito_q  <= 1'b0;
            parada_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            escreve_q <= escreve_d;
            pronto_q  <= pronto_d;
            aceito_q  <= aceito_d;
            parada_q  <= parada_d;
            erro_q    <= erro_d;
        end
    end

    assign bus.Seletor_W_Data = sel_q;
    assign bus.Reg_Endereco_W = addr_q;
    assign bus.Escreve_Reg    = escreve_q;
    assign bus.Pronto         = pronto_q;
    assign bus.ES_Aceito      = aceito_q;
    assign bus.Parada         = parada_q;
    assign bus.Erro_Protocolo = erro_q;

endmodule
